// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/stall controller with MDU busy FSM (optional HAZARD_PERF_CNT_EN stall counter)
`timescale 1ns/1ps
module hazard_ctrl #(
    parameter int MDU_LAT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] if_id_rs1,
    input  logic [4:0] if_id_rs2,
    input  logic       if_id_use_rs1,
    input  logic       if_id_use_rs2,
    input  logic       if_id_is_branch,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_reg_write,
    input  logic       id_ex_mem_read,
    input  logic [4:0] ex_mem_rd,
    input  logic       ex_mem_mem_read,
    input  logic       ex_mdu_start,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       id_ex_write,
    output logic       id_ex_bubble,
    output logic       ex_mem_bubble,
    output logic       if_id_flush,
    output logic       mdu_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    // The start cycle is one of the MDU_LAT cycles, and cnt==0 is itself a busy
    // cycle, so loading MDU_LAT-2 yields exactly MDU_LAT-1 busy cycles.
    localparam logic [4:0] CNT_INIT = 5'(MDU_LAT - 2);

    state_t     state;
    state_t     state_next;
    logic [4:0] cnt;
    logic [4:0] cnt_next;

    logic       ex_rd_nz;
    logic       mem_rd_nz;
    logic       ex_hit;
    logic       mem_hit;
    logic       load_use;
    logic       branch_hz;
    logic       mdu_stall;

    // FSM state and countdown register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 5'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: start is only honoured in RUN
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RUN: begin
                if (ex_mdu_start) begin
                    state_next = MDU_BUSY;
                    cnt_next   = CNT_INIT;
                end
            end
            MDU_BUSY: begin
                if (cnt == 5'd0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt - 5'd1;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = 5'd0;
            end
        endcase
    end

    // Source/destination matching; x0 never creates a dependency
    always_comb begin
        ex_rd_nz  = (id_ex_rd != 5'd0);
        mem_rd_nz = (ex_mem_rd != 5'd0);
        ex_hit    = (if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
                    (if_id_use_rs2 && (if_id_rs2 == id_ex_rd));
        mem_hit   = (if_id_use_rs1 && (if_id_rs1 == ex_mem_rd)) ||
                    (if_id_use_rs2 && (if_id_rs2 == ex_mem_rd));
        load_use  = id_ex_mem_read && ex_rd_nz && ex_hit;
        branch_hz = if_id_is_branch &&
                    ((id_ex_reg_write && ex_rd_nz && ex_hit) ||
                     (ex_mem_mem_read && mem_rd_nz && mem_hit));
        mdu_stall = ((state == RUN) && ex_mdu_start) || (state == MDU_BUSY);
    end

    // Output priority: reset > MDU > data hazard > flush > normal
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        if_id_flush   = 1'b0;
        if (!rst) begin
            if (mdu_stall) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_bubble = 1'b1;
            end else if (load_use || branch_hz) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_bubble  = 1'b1;
            end else begin
                if_id_flush   = branch_taken;
            end
        end
    end

    assign mdu_busy = (state == MDU_BUSY);

`ifdef HAZARD_PERF_CNT_EN
    // Count every cycle in which the front end is frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 32'd0;
        end else if (!pc_write) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MDU_LAT, default 8, meaning total EX-stage cycles of a multi-cycle multiply/divide op (legal range 2..32).
REQ-002 clk  in  1  pipeline clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 if_id_rs1, if_id_rs2  in  5 each  source registers of the instruction in ID.
REQ-005 if_id_use_rs1, if_id_use_rs2  in  1 each  ID instruction actually reads that source.
REQ-006 if_id_is_branch  in  1  ID instruction is a branch/JALR resolved in ID.
REQ-007 id_ex_rd  in  5; id_ex_reg_write  in  1; id_ex_mem_read  in  1  destination and control of the instruction in EX.
REQ-008 ex_mem_rd  in  5; ex_mem_mem_read  in  1  destination and load flag of the instruction in MEM.
REQ-009 ex_mdu_start  in  1  EX holds a multi-cycle MDU op in its first EX cycle.
REQ-010 branch_taken  in  1  ID branch resolved taken this cycle.
REQ-011 pc_write, if_id_write, id_ex_write  out  1 each  pipeline-register write enables.
REQ-012 id_ex_bubble, ex_mem_bubble  out  1 each  insert NOP into ID/EX, EX/MEM.
REQ-013 if_id_flush  out  1  squash the IF/ID instruction.
REQ-014 mdu_busy  out  1  FSM in MDU_BUSY.

Function
REQ-015 The FSM SHALL have states RUN and MDU_BUSY, plus a 5-bit down-counter cnt.
REQ-016 In RUN, ex_mdu_start=1 SHALL load cnt=MDU_LAT-2 and move to MDU_BUSY at the next edge; ex_mdu_start SHALL be ignored in MDU_BUSY.
REQ-017 In MDU_BUSY, cnt SHALL decrement each cycle; at cnt==0 the FSM SHALL return to RUN on the next edge. The stall lasts exactly MDU_LAT-1 cycles after the start cycle.
REQ-018 During the start cycle and all MDU_BUSY cycles: pc_write=if_id_write=id_ex_write=0, ex_mem_bubble=1, id_ex_bubble=0, if_id_flush=0, mdu_busy=1 in MDU_BUSY only.
REQ-019 Load-use hazard = id_ex_mem_read & id_ex_rd!=0 & ((use_rs1 & rs1==id_ex_rd) | (use_rs2 & rs2==id_ex_rd)).
REQ-020 Branch hazard = if_id_is_branch & [(id_ex_reg_write & id_ex_rd!=0 & rd matches a used source) | (ex_mem_mem_read & ex_mem_rd!=0 & ex_mem_rd matches a used source)].
REQ-021 In RUN without MDU start, a load-use or branch hazard SHALL give pc_write=if_id_write=0, id_ex_bubble=1, id_ex_write=1, if_id_flush=0.
REQ-022 A branch depending on a load in EX therefore stalls 2 cycles (EX, then MEM match); dependent on an ALU op in EX, 1 cycle.
REQ-023 With no stall, if_id_flush SHALL equal branch_taken; it SHALL be 0 whenever any stall is asserted.
REQ-024 Priority: MDU start/busy > load-use/branch hazard > flush > normal (all enables 1, bubbles/flush 0).
REQ-025 Hazard outputs SHALL be combinational from state and inputs; no added latency.

Reset
REQ-026 rst SHALL force state=RUN, cnt=0, mdu_busy=0 immediately, including mid-MDU_BUSY.
REQ-027 While rst=1: pc_write=if_id_write=id_ex_write=1; id_ex_bubble=ex_mem_bubble=if_id_flush=0 regardless of inputs.

Configuration
REQ-028 Macro HAZARD_PERF_CNT_EN: when defined, the block SHALL add output stall_cycles (32 bits) counting cycles with pc_write=0, reset to 0, wrapping at 2^32; when undefined, neither the port nor the counter SHALL exist and all other behaviour is identical.

Verification
REQ-029 lw x5 in EX, ID add uses x5 -> one cycle pc_write=0, id_ex_bubble=1, then normal.
REQ-030 lw x5 in EX, ID beq uses x5 -> 2 stall cycles, then branch_taken=1 -> if_id_flush=1 for 1 cycle.
REQ-031 ex_mdu_start=1, MDU_LAT=8 -> pc_write=0 for 8 cycles total (start + 7 busy), mdu_busy=1 for 7, back to RUN.
REQ-032 rst pulsed at busy cycle 3 -> mdu_busy=0 asynchronously, outputs return to reset values, no residual stall.
REQ-033 id_ex_rd=0 with mem_read=1, rs1=0 -> no stall; ex_mdu_start with simultaneous load-use -> MDU stall wins, load-use re-evaluated after.
REQ-034 With HAZARD_PERF_CNT_EN: REQ-031 sequence -> stall_cycles=8.
